// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary conversion paths: FSM states,
// digit-adjust constants and the binary width needed for a given digit count.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } bcd_state_e;

   localparam logic [3:0] ADJ_THRESH = 4'd8;
   localparam logic [3:0] ADJ_VAL    = 4'd3;
   localparam logic [3:0] MAX_DIGIT  = 4'd9;

   // Minimum binary width that can hold 10^digits - 1.
   function automatic int bcd_bin_width(input int digits);
      case (digits)
         1:       return 4;
         2:       return 7;
         3:       return 10;
         default: return 14;
      endcase
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: a digit that reads 8 or more after
// the right shift had a carry-in worth 8 that is really 5, so subtract 3.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   assign digit_o = (digit_i >= ADJ_THRESH) ? (digit_i - ADJ_VAL) : digit_i;

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one shift per cycle).
// Optional input digit checking is enabled with `define BCD_TO_BINARY_CHECK_EN.
module bcd_to_binary
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   in_bcd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bin,
   output logic                  out_err,
   output logic [1:0]            dbg_state_o,
   output logic [4*DIGITS-1:0]   dbg_sr_o,
   output logic [3:0]            dbg_cnt_o
);

   localparam int W     = 4 * DIGITS;
   localparam int ITERS = bcd_bin_width(DIGITS);
   localparam logic [3:0] LAST_CNT = 4'(ITERS - 1);

   bcd_state_e        state_q, state_d;
   logic [W-1:0]      sr_q, sr_d;
   logic [ITERS-1:0]  res_q, res_d;
   logic [3:0]        cnt_q, cnt_d;

   logic [W-1:0]      sr_shift;
   logic [W-1:0]      sr_adj;

   assign sr_shift = sr_q >> 1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_i (sr_shift[4*g +: 4]),
         .digit_o (sr_adj[4*g +: 4])
      );
   end

`ifdef BCD_TO_BINARY_CHECK_EN
   logic err_q, err_d;
   logic in_bad;

   always_comb begin
      in_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (in_bcd[4*i +: 4] > MAX_DIGIT) in_bad = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign out_err = err_q;
`else
   assign out_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sr_q    <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
`ifdef BCD_TO_BINARY_CHECK_EN
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sr_d    = in_bcd;
               res_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
`ifdef BCD_TO_BINARY_CHECK_EN
               err_d = in_bad;
               // A bad word never enters the shifter; report it straight away.
               if (in_bad) begin
                  sr_d    = '0;
                  state_d = DONE;
               end
`endif
            end
         end
         SHIFT: begin
            // {sr,res} >> 1: the LSB of sr drops into the top of res.
            sr_d  = sr_adj;
            res_d = {sr_q[0], res_q[ITERS-1:1]};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST_CNT) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   assign out_bin     = W'(res_q);
   assign dbg_state_o = state_q;
   assign dbg_sr_o    = sr_q;
   assign dbg_cnt_o   = cnt_q;

endmodule

// File: doc/bcd_to_binary.md
# bcd_to_binary

Sequential BCD-to-binary converter, the inverse of the combinational binary-to-BCD path that feeds the display. It accepts a packed BCD word over a valid/ready handshake and runs reverse double-dabble: shift right one bit per cycle, then subtract 3 from any BCD digit ≥ 8. It returns the binary value over a second valid/ready handshake. It sits between BCD switch/keypad entry and the datapath that loads immediates into the pipeline.

## Interface
Parameters:
- DIGITS, 4: number of BCD digits (1..4). Input width is 4*DIGITS.
- ITERS, derived from DIGITS (not overridable): shift count, equal to the minimum binary width for 10^DIGITS−1. Values: 1→4, 2→7, 3→10, 4→14.

Ports:
- clk, input, 1: clock. One clock domain; reset is asynchronous and active-low.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: in_bcd is valid.
- in_ready, output, 1: block can accept a word; high only in IDLE.
- in_bcd, input, 4*DIGITS: packed BCD, digit 0 in bits [3:0].
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer takes the result.
- out_bin, output, 4*DIGITS: binary result, zero-extended above ITERS bits.
- out_err, output, 1: invalid digit detected (see Configuration).

## Operation
- States are IDLE, SHIFT and DONE.
- IDLE: in_ready=1. When in_valid is high at a clock edge:
  - latch in_bcd into the shift register sr;
  - clear the result register res;
  - set cnt=0;
  - go to SHIFT.
- SHIFT, one iteration per cycle:
  - form {sr,res} >> 1, so sr[0] enters the MSB of the ITERS-bit res;
  - for each digit of the shifted sr with value ≥ 8, subtract 3 from that digit;
  - cnt increments each cycle;
  - when cnt==ITERS−1, go to DONE.
- DONE: out_valid=1, and out_bin and out_err are held stable. When out_ready is high at an edge, go to IDLE.
- out_bin is driven from res, not combinationally from in_bcd.
- After ITERS iterations of a valid input, sr is zero. The bench may check this through a debug probe only.
- in_valid while not in IDLE is ignored; the upstream holds its data until in_ready is high.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_bin=0, out_err=0, cnt=0, sr=0.
- Latency: acceptance edge T0, shift edges T1..TITERS, out_valid high after edge TITERS. With DIGITS=4 this is 14 cycles.
- Throughput with out_ready held high: 16 cycles per conversion at DIGITS=4 (accept, 14 shifts, drain). The next in_ready is high after edge T15.
- Backpressure: out_valid stays high and out_bin stays unchanged for any number of cycles until out_ready is high.
- Reset asserted in any state, including mid-SHIFT: immediate return to reset values. The in-flight conversion is discarded and no partial out_valid is produced.
- in_valid and out_ready high in the same cycle in DONE: only the output handshake completes. The input is accepted no earlier than the following IDLE cycle.

## Configuration
- Macro: BCD_TO_BINARY_CHECK_EN.
- Defined:
  - at acceptance, any digit of in_bcd > 9 skips SHIFT and goes directly to DONE on the next edge;
  - in that case out_err=1 and out_bin=0;
  - valid inputs behave as above with out_err=0.
- Undefined:
  - no digit check; out_err is tied to 0;
  - invalid digits are converted by the algorithm as-is, the result is unspecified, and timing is unchanged.

## Structure
- Shared package bcd_pkg:
  - state enum (IDLE/SHIFT/DONE);
  - function bcd_bin_width(digits) returning ITERS;
  - localparams ADJ_THRESH=8 and ADJ_VAL=3;
  - the max-digit constant 9, also used by the existing binary-to-BCD path.
- Sub-module bcd_digit_adj: one 4-bit digit in, digit minus 3 if ≥ 8 out. Instantiated DIGITS times with a generate loop.

## Test plan
- in_bcd=16'h1234, out_ready=1 → out_valid exactly 14 cycles after acceptance; out_bin=16'd1234 (16'h04D2); out_err=0.
- in_bcd=16'h9999, then 16'h0000, back-to-back → out_bin=16'h270F then 16'h0000; second acceptance 16 cycles after the first.
- in_bcd=16'h0510 with out_ready low for 10 cycles after out_valid → out_bin=16'd510 stable throughout, in_ready=0 throughout; completes on the first out_ready.
- rst_n pulsed low at cycle 7 of SHIFT (in_bcd=16'h4321) → all outputs at reset values immediately; next word 16'h0042 converts to 16'd42.
- With BCD_TO_BINARY_CHECK_EN, in_bcd=16'h12A4 → out_valid one cycle after acceptance, out_err=1, out_bin=0. Without it: out_err=0 and latency of 14 cycles.
- Sweep all 0..9999 encoded as BCD (optionally run with random out_ready) → out_bin equals the decimal value in every case.
